// File: rtl/mul_pipeline_pkg.sv
// ============================================================================
// Module : mul_pipeline_pkg
// Brief  : RV32/64 M-extension decode constants and multiply-mode encoding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mul_pipeline_pkg;

  localparam int OPCODE_SIZE = 7;
  localparam int FUNCT7_SIZE = 7;
  localparam int FUNCT3_SIZE = 3;

  localparam logic [OPCODE_SIZE-1:0] OPCODE_OP = 7'b0110011;
  localparam logic [FUNCT7_SIZE-1:0] F7_MULDIV = 7'b0000001;

  localparam logic [FUNCT3_SIZE-1:0] F3_MUL    = 3'b000;
  localparam logic [FUNCT3_SIZE-1:0] F3_MULH   = 3'b001;
  localparam logic [FUNCT3_SIZE-1:0] F3_MULHSU = 3'b010;
  localparam logic [FUNCT3_SIZE-1:0] F3_MULHU  = 3'b011;

  typedef enum logic [1:0] {
    MUL_LO  = 2'd0,
    MUL_HSS = 2'd1,
    MUL_HSU = 2'd2,
    MUL_HUU = 2'd3
  } mul_op_t;

  localparam int MUL_OP_W = 2;

  function automatic mul_op_t f3_to_op(input logic [FUNCT3_SIZE-1:0] f3);
    case (f3)
      F3_MULH:   return MUL_HSS;
      F3_MULHSU: return MUL_HSU;
      F3_MULHU:  return MUL_HUU;
      default:   return MUL_LO;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mul_pipeline_if.sv
// ============================================================================
// Module : mul_pipeline_if
// Brief  : Issue/result bundle between the execute stage and mul_pipeline.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mul_pipeline_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  import mul_pipeline_pkg::*;

  logic                   valid_i;
  logic [OPCODE_SIZE-1:0] opcode_i;
  logic [FUNCT7_SIZE-1:0] funct7_i;
  logic [FUNCT3_SIZE-1:0] funct3_i;
  logic [WIDTH-1:0]       op1_data_i;
  logic [WIDTH-1:0]       op2_data_i;
  logic [TAG_W-1:0]       tag_i;
  logic                   stall_i;
  logic                   kill_i;
  logic                   valid_o;
  logic [WIDTH-1:0]       result_o;
  logic [TAG_W-1:0]       tag_o;
  logic                   busy_o;

  modport master (
    output valid_i, opcode_i, funct7_i, funct3_i, op1_data_i, op2_data_i,
           tag_i, stall_i, kill_i,
    input  valid_o, result_o, tag_o, busy_o
  );

  modport slave (
    input  valid_i, opcode_i, funct7_i, funct3_i, op1_data_i, op2_data_i,
           tag_i, stall_i, kill_i,
    output valid_o, result_o, tag_o, busy_o
  );

endinterface

`default_nettype wire

// File: rtl/mul_pipeline_stage.sv
// ============================================================================
// Module : mul_pipe_stage
// Brief  : One pipeline register: valid, tag and payload with stall and kill.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mul_pipe_stage #(
  parameter int TAG_W  = 5,
  parameter int DATA_W = 66
) (
  input  wire logic              clk,
  input  wire logic              reset_n,
  input  wire logic              stall,
  input  wire logic              kill,
  input  wire logic              in_valid,
  input  wire logic [TAG_W-1:0]  in_tag,
  input  wire logic [DATA_W-1:0] in_data,
  output logic                   out_valid,
  output logic [TAG_W-1:0]       out_tag,
  output logic [DATA_W-1:0]      out_data
);

  // Payload only loads behind a valid op so the last stage keeps showing the
  // most recent real result while the pipe drains or idles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_tag   <= '0;
      out_data  <= '0;
    end else if (kill) begin
      out_valid <= 1'b0;
    end else if (!stall) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_tag  <= in_tag;
        out_data <= in_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mul_pipeline.sv
// ============================================================================
// Module : mul_pipeline
// Brief  : Fully pipelined MUL/MULH/MULHSU/MULHU unit with tag, stall, kill.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mul_pipeline
  import mul_pipeline_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 5,
  parameter int TAG_W  = 5
) (
  input  wire logic     clk,
  input  wire logic     reset_n,
  mul_pipeline_if.slave bus
);

  localparam int PROD_W = 2 * WIDTH;
  localparam int DATA_W = PROD_W + MUL_OP_W;

  logic              f3_hit;
  logic              issue_hit;
  mul_op_t           in_op;
  logic              op1_signed;
  logic              op2_signed;
  logic [PROD_W-1:0] op1_ext;
  logic [PROD_W-1:0] op2_ext;
  logic [PROD_W-1:0] product;

  logic              stg_valid [STAGES+1];
  logic [TAG_W-1:0]  stg_tag   [STAGES+1];
  logic [DATA_W-1:0] stg_data  [STAGES+1];

  mul_op_t           out_op;
  logic [PROD_W-1:0] out_prod;
  logic              busy;

  always_comb begin
    f3_hit    = bus.funct3_i inside {F3_MUL, F3_MULH, F3_MULHSU, F3_MULHU};
    issue_hit = bus.valid_i && (bus.opcode_i == OPCODE_OP) &&
                (bus.funct7_i == F7_MULDIV) && f3_hit;
    in_op     = f3_to_op(bus.funct3_i);
  end

  // Only the low 2*WIDTH bits of the (2*WIDTH+2)-bit signed product are ever
  // selected, and those are identical for any extension to at least 2*WIDTH.
  always_comb begin
    op1_signed = (in_op != MUL_HUU);
    op2_signed = (in_op == MUL_HSS) || (in_op == MUL_LO);
    op1_ext    = {{WIDTH{op1_signed & bus.op1_data_i[WIDTH-1]}}, bus.op1_data_i};
    op2_ext    = {{WIDTH{op2_signed & bus.op2_data_i[WIDTH-1]}}, bus.op2_data_i};
    product    = op1_ext * op2_ext;
  end

  assign stg_valid[0] = issue_hit;
  assign stg_tag[0]   = bus.tag_i;
  assign stg_data[0]  = {in_op, product};

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    mul_pipe_stage #(
      .TAG_W  (TAG_W),
      .DATA_W (DATA_W)
    ) u_stage (
      .clk       (clk),
      .reset_n   (reset_n),
      .stall     (bus.stall_i),
      .kill      (bus.kill_i),
      .in_valid  (stg_valid[i]),
      .in_tag    (stg_tag[i]),
      .in_data   (stg_data[i]),
      .out_valid (stg_valid[i+1]),
      .out_tag   (stg_tag[i+1]),
      .out_data  (stg_data[i+1])
    );
  end

  always_comb begin
    out_op   = mul_op_t'(stg_data[STAGES][DATA_W-1 -: MUL_OP_W]);
    out_prod = stg_data[STAGES][PROD_W-1:0];
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 1; i <= STAGES; i++) begin
      busy = busy | stg_valid[i];
    end
  end

  assign bus.valid_o  = stg_valid[STAGES];
  assign bus.tag_o    = stg_tag[STAGES];
  assign bus.result_o = (out_op == MUL_LO) ? out_prod[WIDTH-1:0]
                                           : out_prod[PROD_W-1:WIDTH];
  assign bus.busy_o   = busy;

endmodule

`default_nettype wire
